mdac_btn_ctrl: RTL

//   Front-end sequencer for the MDAC button path. Synchronises and debounces btn_raw.

---
 rtl/mdac_pkg.sv | 15 +
 rtl/mdac_sync.sv | 27 ++
 rtl/mdac_btn_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mdac_pkg.sv
// Shared definitions for the MDAC button front-end: FSM state encoding and
// default sizing for the button path.
package mdac_pkg;

  localparam int BTN_COUNT        = 4;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEB      = 2'd1,
    ISSUE    = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

endpackage

// File: rtl/mdac_sync.sv
// Multi-bit two-flop synchroniser for the raw button pins.
// Each bit is synchronised on its own; no bus coherency is implied.
module mdac_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/mdac_btn_ctrl.sv
// MDAC button sequencer: synchronise, debounce, issue one command per press
// over valid/ready, then lock out until all buttons stay released.
module mdac_btn_ctrl
  import mdac_pkg::*;
#(
  parameter int N_BTN           = BTN_COUNT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int ID_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             cmd_ready,
  output logic [N_BTN-1:0] btn_q,
  output logic             invalid,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic             err_pulse,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0] sample_q, sample_d;
  logic [N_BTN-1:0] btn_vec_q, btn_vec_d;
  logic             invalid_q, invalid_d;
  logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [N_BTN-1:0] btn_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic is_one_hot(input logic [N_BTN-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [ID_W-1:0] encode(input logic [N_BTN-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  mdac_sync #(.WIDTH(N_BTN)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (btn_raw),
    .sync_o  (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sample_q  <= '0;
      btn_vec_q <= '0;
      invalid_q <= 1'b0;
      cmd_id_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      btn_vec_q <= btn_vec_d;
      invalid_q <= invalid_d;
      cmd_id_q  <= cmd_id_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // The release counter restarts on every entry to WAIT_REL so the lockout
  // always spans a full debounce window of released buttons.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    btn_vec_d = btn_vec_q;
    invalid_d = invalid_q;
    cmd_id_d  = cmd_id_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s != '0) begin
          state_d  = DEB;
          sample_d = btn_s;
          cnt_d    = '0;
        end
      end
      DEB: begin
        if (btn_s != sample_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          btn_vec_d = sample_q;
          cnt_d     = '0;
          if (is_one_hot(sample_q)) begin
            state_d   = ISSUE;
            invalid_d = 1'b0;
            cmd_id_d  = encode(sample_q);
          end else begin
            state_d   = WAIT_REL;
            invalid_d = 1'b1;
            err_d     = 1'b1;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end
      end
      WAIT_REL: begin
        if (btn_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          btn_vec_d = '0;
          invalid_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    cmd_valid = (state_q == ISSUE);
    btn_q     = btn_vec_q;
    invalid   = invalid_q;
    cmd_id    = cmd_id_q;
    err_pulse = err_q;
    busy      = busy_q;
  end

endmodule
